// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one registered lookahead carry adder among NREQ requesters.
// Includes the combinational lookahead_carry_adder it wraps.
module lookahead_carry_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] g;
    logic [WIDTH:0] p;
    // Kogge-Stone prefix; position 0 carries cin so g[i] ends as the carry into bit i
    always_comb begin
        g = {a & b, cin};
        p = {a ^ b, 1'b0};
        for (int d = 1; d <= WIDTH; d = d * 2) begin
            for (int i = WIDTH; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        sum = (a ^ b) ^ g[WIDTH-1:0];
        cout = g[WIDTH];
    end
endmodule

module adder_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ = 4,
    parameter int IDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);
    logic v1, v2, ld1, ld2, gnt_any, cin1, cout;
    logic [IDW-1:0] ptr, gnt, id1, cand;
    logic [IDW:0] idx;
    logic [WIDTH-1:0] a1, b1, sum;

    assign ld2 = !v2 || rsp_ready;
    assign ld1 = !v1 || ld2;
    assign rsp_valid = v2;
    assign busy = v1 || v2;

    // scan from the highest offset down so the nearest requester after ptr wins
    always_comb begin
        gnt_any = 1'b0;
        gnt = '0;
        idx = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            idx = (idx >= (IDW+1)'(NREQ)) ? idx - (IDW+1)'(NREQ) : idx;
            cand = idx[IDW-1:0];
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (ld1 && gnt_any && !rst) req_ready[gnt] = 1'b1;
    end

    lookahead_carry_adder #(.WIDTH(WIDTH)) u_add (
        .a(a1), .b(b1), .cin(cin1), .sum(sum), .cout(cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            ptr <= '0;
            a1 <= '0;
            b1 <= '0;
            cin1 <= 1'b0;
            id1 <= '0;
            rsp_id <= '0;
            rsp_sum <= '0;
            rsp_cout <= 1'b0;
        end else begin
            if (ld1) v1 <= gnt_any;
            if (ld1 && gnt_any) begin
                a1 <= req_a[int'(gnt)*WIDTH +: WIDTH];
                b1 <= req_b[int'(gnt)*WIDTH +: WIDTH];
                cin1 <= req_cin[gnt];
                id1 <= gnt;
                ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
            end
            if (ld2) v2 <= v1;
            if (ld2 && v1) begin
                rsp_sum <= sum;
                rsp_cout <= cout;
                rsp_id <= id1;
            end
        end
    end
endmodule
